// File: rtl/mioc_dram_seq_pkg.sv
// Shared types and default timing for the MIOC DRAM strobe sequencer.
// The FSM encoding and counter width are fixed here so the counter and the top agree.
package mioc_dram_seq_pkg;

   localparam int CNT_W = 4;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RAS  = 3'd1,
      ST_MUXW = 3'd2,
      ST_CAS  = 3'd3,
      ST_PRE  = 3'd4,
      ST_REF  = 3'd5
   } state_t;

   // Refresh walks the shared counter through the three access phases in turn.
   typedef enum logic [1:0] {
      RP_ROW = 2'd0,
      RP_MUX = 2'd1,
      RP_CAS = 2'd2
   } ref_ph_t;

   localparam int DEF_NBANK    = 2;
   localparam int DEF_BANK_W   = 1;
   localparam int DEF_RAS2MUX  = 1;
   localparam int DEF_MUX2CAS  = 1;
   localparam int DEF_CAS_W    = 2;
   localparam int DEF_PRECHG   = 2;
   localparam int DEF_WAIT_CYC = 0;

   // A phase of N cycles loads N-1; the counter reads zero on its last cycle.
   function automatic cnt_t cyc2cnt(input int cyc);
      return cnt_t'(cyc - 1);
   endfunction

endpackage

// File: rtl/mioc_dram_seq_dly_cnt.sv
// Shared phase timer: load on state entry, count down to zero and hold there.
// done_o is high on the last cycle of the loaded phase.
module mioc_dram_seq_dly_cnt
   import mioc_dram_seq_pkg::*;
(
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic ld_i,
   input  cnt_t val_i,
   output logic done_o
);

   cnt_t cnt_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else if (ld_i) begin
         cnt_q <= val_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - cnt_t'(1);
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mioc_dram_seq.sv
// DRAM strobe sequencer: RAS/MUX/CAS/WAIT from the buffered Z80 bus, RAS-only refresh,
// and the 6801 DMA bus-request handshake. All outputs are registered.
module mioc_dram_seq
   import mioc_dram_seq_pkg::*;
#(
   parameter int NBANK    = DEF_NBANK,
   parameter int BANK_W   = DEF_BANK_W,
   parameter int RAS2MUX  = DEF_RAS2MUX,
   parameter int MUX2CAS  = DEF_MUX2CAS,
   parameter int CAS_W    = DEF_CAS_W,
   parameter int PRECHG   = DEF_PRECHG,
   parameter int WAIT_CYC = DEF_WAIT_CYC
) (
   input  logic              b_phi_i,
   input  logic              rst_n_i,
   input  logic              bmreq_n_i,
   input  logic              brfsh_n_i,
   input  logic              brd_n_i,
   input  logic              n_bwr_i,
   input  logic              bm1_n_i,
   input  logic [BANK_W-1:0] bank_i,
   input  logic              dma_n_i,
   input  logic              busak_n_i,
   output logic              ras_n_o,
   output logic              mux_o,
   output logic [NBANK-1:0]  cas_n_o,
   output logic              wait_n_o,
   output logic              busrq_n_o,
   output logic              busy_o
);

   state_t              state_q, state_d;
   ref_ph_t             ref_ph_q, ref_ph_d;

   logic                bmreq_q, bmreq_hist_q;
   logic                brfsh_q, brd_q, bwr_q, bm1_q, dma_q;
   logic                pend_q, pend_ref_q;
   logic [BANK_W-1:0]   bank_q;
   cnt_t                wait_cnt_q;

   logic                ras_n_q, mux_q, wait_n_q, busrq_n_q, busy_q;
   logic [NBANK-1:0]    cas_n_q;

   logic                fell, rd_wr;
   logic                start_req, start_ref;
   logic                cnt_ld, cnt_done;
   cnt_t                cnt_val;
   logic [NBANK-1:0]    cas_sel;

   // Bus acknowledge is status only; strobe timing never depends on it.
   logic                unused_busak;
   assign unused_busak = busak_n_i;

   assign fell  = bmreq_hist_q & ~bmreq_q;
   assign rd_wr = ~brd_q | ~bwr_q;

   // An out-of-range bank leaves every CAS bit idle but keeps the timing.
   always_comb begin
      cas_sel = '0;
      for (int b = 0; b < NBANK; b++) begin
         if (int'(bank_q) == b) cas_sel[b] = 1'b1;
      end
   end

   mioc_dram_seq_dly_cnt u_cnt (
      .clk_i   (b_phi_i),
      .rst_n_i (rst_n_i),
      .ld_i    (cnt_ld),
      .val_i   (cnt_val),
      .done_o  (cnt_done)
   );

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d   = state_q;
      ref_ph_d  = ref_ph_q;
      cnt_ld    = 1'b0;
      cnt_val   = '0;
      start_req = 1'b0;
      start_ref = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (fell) begin
               start_req = 1'b1;
               start_ref = ~brfsh_q;
            end
         end
         ST_RAS: begin
            if (cnt_done) begin
               state_d = ST_MUXW;
               cnt_ld  = 1'b1;
               cnt_val = cyc2cnt(MUX2CAS);
            end
         end
         ST_MUXW: begin
            if (cnt_done && rd_wr) begin
               state_d = ST_CAS;
               cnt_ld  = 1'b1;
               cnt_val = cyc2cnt(CAS_W);
            end else if (bmreq_q && !rd_wr) begin
               state_d = ST_PRE;
               cnt_ld  = 1'b1;
               cnt_val = cyc2cnt(PRECHG);
            end
         end
         ST_CAS: begin
            if (cnt_done) begin
               state_d = ST_PRE;
               cnt_ld  = 1'b1;
               cnt_val = cyc2cnt(PRECHG);
            end
         end
         ST_PRE: begin
            if (cnt_done) begin
               if (pend_q) begin
                  start_req = 1'b1;
                  start_ref = pend_ref_q;
               end else if (fell) begin
                  start_req = 1'b1;
                  start_ref = ~brfsh_q;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_REF: begin
            if (cnt_done) begin
               cnt_ld = 1'b1;
               case (ref_ph_q)
                  RP_ROW: begin
                     ref_ph_d = RP_MUX;
                     cnt_val  = cyc2cnt(MUX2CAS);
                  end
                  RP_MUX: begin
                     ref_ph_d = RP_CAS;
                     cnt_val  = cyc2cnt(CAS_W);
                  end
                  default: begin
                     state_d = ST_PRE;
                     cnt_val = cyc2cnt(PRECHG);
                  end
               endcase
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Both an access and a refresh open with the row phase.
      if (start_req) begin
         state_d  = start_ref ? ST_REF : ST_RAS;
         ref_ph_d = RP_ROW;
         cnt_ld   = 1'b1;
         cnt_val  = cyc2cnt(RAS2MUX);
      end
   end

   // History resets to "low seen" so a request held low through reset never restarts.
   always_ff @(posedge b_phi_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= ST_IDLE;
         ref_ph_q     <= RP_ROW;
         bmreq_q      <= 1'b0;
         bmreq_hist_q <= 1'b0;
         brfsh_q      <= 1'b1;
         brd_q        <= 1'b1;
         bwr_q        <= 1'b1;
         bm1_q        <= 1'b1;
         dma_q        <= 1'b1;
         pend_q       <= 1'b0;
         pend_ref_q   <= 1'b0;
         bank_q       <= '0;
         wait_cnt_q   <= '0;
         ras_n_q      <= 1'b1;
         mux_q        <= 1'b0;
         cas_n_q      <= '1;
         wait_n_q     <= 1'b1;
         busrq_n_q    <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so every register here sees pre-edge values.
         bmreq_q      <= bmreq_n_i;
         bmreq_hist_q <= bmreq_q;
         brfsh_q      <= brfsh_n_i;
         brd_q        <= brd_n_i;
         bwr_q        <= n_bwr_i;
         bm1_q        <= bm1_n_i;
         dma_q        <= dma_n_i;
         state_q      <= state_d;
         ref_ph_q     <= ref_ph_d;

         if (start_req) begin
            pend_q <= 1'b0;
            if (!start_ref) bank_q <= bank_i;
         end else if (fell && state_q != ST_IDLE && !pend_q) begin
            pend_q     <= 1'b1;
            pend_ref_q <= ~brfsh_q;
         end

         ras_n_q <= (state_d == ST_IDLE) || (state_d == ST_PRE);
         mux_q   <= (state_d == ST_MUXW) || (state_d == ST_CAS);
         cas_n_q <= (state_d == ST_CAS) ? ~cas_sel : '1;
         busy_q  <= (state_d != ST_IDLE);

         if (WAIT_CYC > 0 && start_req && !start_ref && !bm1_q) begin
            wait_n_q   <= 1'b0;
            wait_cnt_q <= cyc2cnt(WAIT_CYC);
         end else if (!wait_n_q) begin
            if (wait_cnt_q == '0) wait_n_q <= 1'b1;
            else                  wait_cnt_q <= wait_cnt_q - cnt_t'(1);
         end

         // Bus request drops at once but is only released outside an active cycle.
         if (!dma_q) begin
            busrq_n_q <= 1'b0;
         end else if (state_q == ST_IDLE || state_q == ST_PRE) begin
            busrq_n_q <= 1'b1;
         end
      end
   end

   assign ras_n_o   = ras_n_q;
   assign mux_o     = mux_q;
   assign cas_n_o   = cas_n_q;
   assign wait_n_o  = wait_n_q;
   assign busrq_n_o = busrq_n_q;
   assign busy_o    = busy_q;

endmodule
